// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter state encoding, default register map and parity helper.
// The PARITY state only exists when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam logic [31:0] TX_ADDR_DEF   = 32'h0000_0100;
    localparam logic [31:0] CTRL_ADDR_DEF = 32'h0000_0104;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } uart_state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrapping pointers; a push while full is taken
// only when a pop retires an entry on the same edge.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             wr;
    logic             rd;

    assign rd    = pop && !empty;
    assign wr    = push && (!full || rd);
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign dout  = mem[rptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= wptr + AW'(1);
            if (rd) rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter fed by a store-driven FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frame).
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] TX_ADDR      = TX_ADDR_DEF,
    parameter logic [31:0] CTRL_ADDR    = CTRL_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        tx,
    output logic        busy,
    output logic        full,
    output logic        overflow,
    output logic [31:0] status
);

    localparam int            CW     = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    uart_state_t                 state, state_n;
    logic [CW-1:0]               cnt, cnt_n;
    logic [2:0]                  idx, idx_n;
    logic [7:0]                  sh, sh_n;
    logic                        tx_n;
    logic                        ovf_n;
    logic                        tick;
    logic                        load;
    logic                        pop;
    logic                        push;
    logic                        wr_hit;
    logic                        clr_hit;
    logic                        empty;
    logic [7:0]                  dout;
    logic [$clog2(FIFO_DEPTH):0] count;
    logic                        unused_hi;
`ifdef UART_TX_PARITY_EN
    logic                        par, par_n;
`endif

    assign wr_hit    = MemWrite && DataAdr == TX_ADDR;
    assign clr_hit   = MemWrite && DataAdr == CTRL_ADDR && WriteData[0];
    assign push      = wr_hit && (!full || pop);
    assign ovf_n     = (wr_hit && !push) || (overflow && !clr_hit);
    assign tick      = cnt == '0;
    assign load      = !empty && (state == IDLE || (state == STOP && tick));
    assign busy      = state != IDLE || count != '0;
    assign status    = {29'b0, overflow, full, busy};
    assign unused_hi = ^WriteData[31:8];

    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (WriteData[7:0]),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            sh       <= '0;
            tx       <= 1'b1;
            overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            sh       <= sh_n;
            tx       <= tx_n;
            overflow <= ovf_n;
`ifdef UART_TX_PARITY_EN
            par      <= par_n;
`endif
        end
    end

    // tx_n is the value for the bit that starts at the next edge, so tx stays a plain flop
    always_comb begin
        state_n = state;
        cnt_n   = tick ? RELOAD : cnt - CW'(1);
        idx_n   = idx;
        sh_n    = sh;
        tx_n    = tx;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: begin
                cnt_n = RELOAD;
                tx_n  = 1'b1;
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                    idx_n   = 3'd0;
                    tx_n    = sh[0];
                end
            end
            DATA: begin
                if (tick && idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_n = PARITY;
                    tx_n    = par;
`else
                    state_n = STOP;
                    tx_n    = 1'b1;
`endif
                end else if (tick) begin
                    idx_n = idx + 3'd1;
                    sh_n  = {1'b0, sh[7:1]};
                    tx_n  = sh[1];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_n = IDLE;
                    tx_n    = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
        if (load) begin
            pop     = 1'b1;
            state_n = START;
            cnt_n   = RELOAD;
            sh_n    = dout;
            tx_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_n   = even_parity(dout);
`endif
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bench with a byte scoreboard and a serial-line frame decoder.
module tb_mmio_uart_tx;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;
    localparam logic [31:0] TXA   = 32'h0000_0100;
    localparam logic [31:0] CTRLA = 32'h0000_0104;
`ifdef UART_TX_PARITY_EN
    localparam int          NB    = 11;
`else
    localparam int          NB    = 10;
`endif

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        tx;
    logic        busy;
    logic        full;
    logic        overflow;
    logic [31:0] status;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [7:0]  sb[$];
    int          n;

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .TX_ADDR      (TXA),
        .CTRL_ADDR    (CTRLA)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .tx        (tx),
        .busy      (busy),
        .full      (full),
        .overflow  (overflow),
        .status    (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [NB-1:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    task automatic store(input logic [31:0] a, input logic [31:0] d, input bit queued);
        @(negedge clk);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
        if (queued) sb.push_back(d[7:0]);
    endtask

    // Called right after a store edge into an idle transmitter: cycle k samples interval k.
    task automatic check_frame(input logic [7:0] d);
        logic [NB-1:0] f;
        f = frame_of(d);
        @(negedge clk);
        chk("frame_pre_tx", tx, 1);
        chk("frame_pre_busy", busy, 1);
        for (int c = 1; c <= NB * CPB; c++) begin
            @(negedge clk);
            chk("frame_bit", tx, f[(c - 1) / CPB]);
        end
        chk("frame_busy_stop", busy, 1);
        @(negedge clk);
        chk("frame_post_tx", tx, 1);
        chk("frame_post_busy", busy, 0);
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (cyc < 3000 && (busy !== 1'b0 || sb.size() != 0)) begin
            @(negedge clk);
            cyc++;
        end
        chk("drain_timeout", cyc < 3000, 1);
    endtask

    task automatic mon_frame();
        logic [NB-1:0] fr;
        logic [7:0]    e;
        bit            ab;
        bit            steady;
        ab     = 1'b0;
        steady = 1'b1;
        fr     = '0;
        for (int b = 0; b < NB; b++) begin
            for (int s = 0; s < CPB; s++) begin
                if (b != 0 || s != 0) @(negedge clk);
                if (reset !== 1'b1) ab = 1'b1;
                if (s == 0) fr[b] = tx;
                else if (tx !== fr[b]) steady = 1'b0;
            end
        end
        if (!ab) begin
            chk("mon_pending", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("mon_steady", steady, 1);
                chk("mon_start", fr[0], 0);
                chk("mon_data", fr[8:1], e);
`ifdef UART_TX_PARITY_EN
                chk("mon_parity", fr[9], ^e);
`endif
                chk("mon_stop", fr[NB-1], 1);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && tx === 1'b0) mon_frame();
        end
    end

    initial begin
        reset     = 1'b1;
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
        #3 reset  = 1'b0;
        #9;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_status", status, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        store(TXA, 32'h55, 1'b1);
        check_frame(8'h55);
        wait_idle(n);

        store(TXA, 32'hFFFF_FF81, 1'b1);
        check_frame(8'h81);
        wait_idle(n);

        store(32'h0000_00FC, 32'h5A, 1'b0);
        DataAdr   = TXA;
        WriteData = 32'hAA;
        repeat (50) begin
            @(negedge clk);
            chk("ignore_tx", tx, 1);
            chk("ignore_busy", busy, 0);
        end
        DataAdr   = '0;
        WriteData = '0;

        for (int i = 0; i < 10; i++) begin
            store(TXA, 32'h30 + i, i < 9);
            if (i == 0) chk("fifo_notfull", full, 0);
            if (i == 8) begin
                chk("fifo_full9", full, 1);
                chk("fifo_ovf9", overflow, 0);
            end
            if (i == 9) begin
                chk("fifo_ovf10", overflow, 1);
                chk("fifo_full10", full, 1);
                chk("fifo_status10", status, 32'h7);
            end
        end
        wait_idle(n);
        chk("b2b_cycles", n, 9 * NB * CPB - 7);
        chk("ovf_sticky", overflow, 1);
        chk("ovf_status", status, 32'h4);
        store(CTRLA, 32'h2, 1'b0);
        chk("ovf_noclr", overflow, 1);
        store(CTRLA, 32'h1, 1'b0);
        chk("ovf_clr", overflow, 0);
        chk("clr_status", status, 32'h0);

        store(TXA, 32'hA3, 1'b1);
        store(TXA, 32'h11, 1'b1);
        store(TXA, 32'h22, 1'b1);
        repeat (12) @(negedge clk);
        chk("mid_tx", tx, 0);
        #1 reset = 1'b0;
        #1;
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        chk("abort_full", full, 0);
        chk("abort_status", status, 0);
        sb.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (60) begin
            @(negedge clk);
            chk("after_tx", tx, 1);
            chk("after_busy", busy, 0);
        end
        store(TXA, 32'h3C, 1'b1);
        check_frame(8'h3C);
        wait_idle(n);

`ifdef UART_TX_PARITY_EN
        store(TXA, 32'h07, 1'b1);
        check_frame(8'h07);
        wait_idle(n);
        store(TXA, 32'h03, 1'b1);
        check_frame(8'h03);
        wait_idle(n);
`endif

        chk("end_status", status, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit (>=2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, transmit FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter TX_ADDR, default 32'h0000_0100, data register address.
REQ-004 SHALL have parameter CTRL_ADDR, default 32'h0000_0104, control register address.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port MemWrite  input  1  processor store strobe.
REQ-008 SHALL have port DataAdr  input  32  processor store address.
REQ-009 SHALL have port WriteData  input  32  processor store data.
REQ-010 SHALL have port tx  output  1  serial line, idle high.
REQ-011 SHALL have port busy  output  1  frame in progress or FIFO non-empty.
REQ-012 SHALL have port full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-013 SHALL have port overflow  output  1  sticky dropped-write flag.
REQ-014 SHALL have port status  output  32  {29'b0, overflow, full, busy}, combinational.

Function
REQ-015 SHALL push WriteData[7:0] at a rising edge where MemWrite=1 and DataAdr==TX_ADDR; other addresses are ignored.
REQ-016 SHALL accept a push when count<FIFO_DEPTH, or when full and a pop occurs on the same edge.
REQ-017 SHALL drop a push that is not accepted and set overflow on that edge.
REQ-018 SHALL clear overflow on a store to CTRL_ADDR with WriteData[0]=1; set wins over a simultaneous clear.
REQ-019 SHALL use wrapping read/write pointers, with count in 0..FIFO_DEPTH and no corruption at wrap.
REQ-020 SHALL implement the FSM IDLE->START->DATA->STOP->IDLE; with parity compiled in: DATA->PARITY->STOP.
REQ-021 SHALL, in IDLE with count>0, pop one byte and enter START on the same edge; tx falls in the cycle after the push edge at the earliest.
REQ-022 SHALL hold each of START (0), DATA bits (LSB first), PARITY and STOP (1) for exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded at each bit boundary.
REQ-023 SHALL, at the end of STOP with count>0, pop the next byte and enter START directly (no idle gap).
REQ-024 SHALL drive tx from a register (glitch-free); tx=1 in IDLE.
REQ-025 SHALL drive busy = (state!=IDLE) or (count!=0).

Reset
REQ-026 SHALL, while reset=0, immediately force tx=1, state=IDLE, count=0, pointers=0, overflow=0, busy=0, full=0.
REQ-027 SHALL abort any frame in progress on reset; no partial frame resumes after release.

Configuration
REQ-028 SHALL honour macro UART_TX_PARITY_EN: when defined, add a PARITY bit equal to the XOR of the 8 data bits (even parity), giving an 11-bit frame.
REQ-029 SHALL, without UART_TX_PARITY_EN, have no PARITY state and send a 10-bit frame.

Structure
REQ-030 SHALL place the FSM state enum and default TX_ADDR/CTRL_ADDR constants in shared package uart_pkg.
REQ-031 SHALL implement the FIFO as sub-module sync_fifo (push/pop/full/empty/count), instantiated once.

Verification
REQ-032 SHALL cover: CLKS_PER_BIT=4, store 0x55 to TX_ADDR -> tx low cycles 1-4 after the store, then 1,0,1,0,1,0,1,0 per 4 cycles, then high; 40-cycle frame; busy falls after stop.
REQ-033 SHALL cover: FIFO_DEPTH=8, 10 back-to-back stores -> 9 frames emitted in order (first popped immediately), 10th dropped, overflow=1, full=1 after store 9.
REQ-034 SHALL cover: store to 0x0000_00FC and a load-only access to TX_ADDR (MemWrite=0) -> tx stays 1, busy=0.
REQ-035 SHALL cover: reset=0 mid-DATA of 0xA3 with 2 bytes queued -> tx=1 the same cycle; after release busy=0 and no output until a new store.
REQ-036 SHALL cover: UART_TX_PARITY_EN defined, store 0x07 -> parity bit 1, 44-cycle frame at CLKS_PER_BIT=4; store 0x03 -> parity bit 0.
REQ-037 SHALL cover: overflow set, then store 0x1 to CTRL_ADDR -> overflow=0, status=32'h0 once idle.
